// File: rtl/amber48_fetch_queue.sv
// ============================================================================
// amber48_fetch_queue : prefetch FIFO front end (fetch PC, imem, decode port)
// Optional same-cycle bypass: AMBER48_FETCH_QUEUE_BYPASS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

package amber48_pkg;
  localparam int unsigned BAU_BYTES = 6;
endpackage

module amber48_fetch_queue #(
  parameter int unsigned     XLEN     = 48,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_INC   = amber48_pkg::BAU_BYTES,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clk_en_i,
  output logic                     imem_req_o,
  output logic [XLEN-1:0]          imem_addr_o,
  input  logic [XLEN-1:0]          imem_data_i,
  input  logic                     imem_valid_i,
  input  logic                     imem_fault_i,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [XLEN-1:0]          dec_pc_o,
  output logic [XLEN-1:0]          dec_instr_o,
  output logic                     dec_fault_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(PC_INC);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;

  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [XLEN-1:0]  pc_mem_d    [DEPTH];
  logic [XLEN-1:0]  instr_mem_q [DEPTH];
  logic [XLEN-1:0]  instr_mem_d [DEPTH];
  logic             fault_mem_q [DEPTH];
  logic             fault_mem_d [DEPTH];

  logic empty;
  logic full;
  logic head_valid;
  logic q_pop;
  logic req;
  logic push;
  logic write;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_CNT);
    head_valid = !empty && !redirect_i;
    q_pop      = head_valid && dec_ready_i;
    // Only a full queue depends on the pop; this keeps req free of any bypass path.
    req        = !halted_q && (!full || q_pop);
    push       = req && imem_valid_i && !redirect_i;
  end

`ifdef AMBER48_FETCH_QUEUE_BYPASS_EN
  logic bypass;

  always_comb begin
    bypass      = empty && push;
    write       = push && !(bypass && dec_ready_i);
    dec_valid_o = head_valid || bypass;
    dec_pc_o    = bypass ? fetch_pc_q   : pc_mem_q[rptr_q];
    dec_instr_o = bypass ? imem_data_i  : instr_mem_q[rptr_q];
    dec_fault_o = bypass ? imem_fault_i : fault_mem_q[rptr_q];
  end
`else
  always_comb begin
    write       = push;
    dec_valid_o = head_valid;
    dec_pc_o    = pc_mem_q[rptr_q];
    dec_instr_o = instr_mem_q[rptr_q];
    dec_fault_o = fault_mem_q[rptr_q];
  end
`endif

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;
  assign count_o     = count_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    halted_d    = halted_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    fault_mem_d = fault_mem_q;
    if (clk_en_i) begin
      if (redirect_i) begin
        fetch_pc_d = redirect_pc_i;
        rptr_d     = '0;
        wptr_d     = '0;
        count_d    = '0;
        halted_d   = 1'b0;
      end else begin
        if (write) begin
          pc_mem_d[wptr_q]    = fetch_pc_q;
          instr_mem_d[wptr_q] = imem_data_i;
          fault_mem_d[wptr_q] = imem_fault_i;
          wptr_d              = wptr_q + PTR_W'(1);
        end
        if (q_pop) begin
          rptr_d = rptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(write) - CNT_W'(q_pop);
        if (push) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          if (imem_fault_i) begin
            halted_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind dec_valid_o.
  always_ff @(posedge clk_i) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
    fault_mem_q <= fault_mem_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_amber48_fetch_queue.sv
// ============================================================================
// tb_amber48_fetch_queue : phase-table stimulus with a queue-based scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_amber48_fetch_queue;

  localparam int unsigned XLEN     = 48;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PC_INC   = 6;
  localparam logic [47:0] RESET_PC = 48'h0;
  localparam logic [47:0] NO_FAULT = 48'hFFFF_FFFF_FFFF;
  localparam int          NVEC     = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        imem_req;
  logic [47:0] imem_addr;
  logic [47:0] imem_data;
  logic        imem_valid;
  logic        imem_fault;
  logic        redirect;
  logic [47:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [47:0] dec_pc;
  logic [47:0] dec_instr;
  logic        dec_fault;
  logic [2:0]  count;

  always #5 clk = ~clk;

  amber48_fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .PC_INC   (PC_INC),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clk_en_i      (clk_en),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .imem_valid_i  (imem_valid),
    .imem_fault_i  (imem_fault),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .dec_valid_o   (dec_valid),
    .dec_ready_i   (dec_ready),
    .dec_pc_o      (dec_pc),
    .dec_instr_o   (dec_instr),
    .dec_fault_o   (dec_fault),
    .count_o       (count)
  );

  typedef struct {
    logic        rst_n;
    logic        clk_en;
    logic        valid;
    logic        ready;
    logic        redir;
    logic [47:0] rpc;
    logic [47:0] fault_pc;
    int          cycles;
    logic [2:0]  exp_count;
    logic [47:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [47:0] pc;
    logic [47:0] instr;
    logic        fault;
  } ent_t;

  ent_t        sb[$];
  logic [47:0] m_fpc = RESET_PC;
  logic        m_halt = 1'b0;
  bit          m_init = 1'b0;
  logic        m_valid, m_pop, m_req, m_push;
  int          n_cmp = 0;
  int          n_fail = 0;
  vec_t        vt[NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rn, input logic ce, input logic v, input logic r,
                              input logic rd, input logic [47:0] rpc, input logic [47:0] fpc,
                              input int n, input logic [2:0] ec, input logic [47:0] ea);
    vec_t x;
    x.rst_n = rn; x.clk_en = ce; x.valid = v; x.ready = r; x.redir = rd;
    x.rpc = rpc; x.fault_pc = fpc; x.cycles = n; x.exp_count = ec; x.exp_addr = ea;
    return x;
  endfunction

  initial begin
    //           rst ce  v  r  rd  rpc       fault_pc  n   count addr
    vt[0]  = mk(0, 1, 0, 0, 0, 48'h0,    NO_FAULT, 2,  3'd0, 48'h0);
    vt[1]  = mk(1, 1, 1, 1, 0, 48'h0,    NO_FAULT, 8,  3'd1, 48'h30);
    vt[2]  = mk(0, 1, 0, 0, 0, 48'h0,    NO_FAULT, 1,  3'd0, 48'h0);
    vt[3]  = mk(1, 1, 1, 0, 0, 48'h0,    NO_FAULT, 6,  3'd4, 48'h18);
    vt[4]  = mk(1, 1, 1, 1, 0, 48'h0,    NO_FAULT, 16, 3'd4, 48'h78);
    vt[5]  = mk(1, 1, 0, 1, 0, 48'h0,    NO_FAULT, 1,  3'd3, 48'h78);
    vt[6]  = mk(1, 1, 1, 1, 1, 48'h1000, NO_FAULT, 1,  3'd0, 48'h1000);
    vt[7]  = mk(1, 1, 1, 1, 0, 48'h0,    NO_FAULT, 3,  3'd1, 48'h1012);
    vt[8]  = mk(1, 1, 1, 0, 1, 48'h0,    NO_FAULT, 1,  3'd0, 48'h0);
    vt[9]  = mk(1, 1, 1, 1, 0, 48'h0,    48'hC,    6,  3'd0, 48'h12);
    vt[10] = mk(1, 1, 1, 0, 1, 48'h40,   NO_FAULT, 1,  3'd0, 48'h40);
    vt[11] = mk(1, 1, 1, 0, 0, 48'h0,    NO_FAULT, 3,  3'd3, 48'h52);
    vt[12] = mk(1, 0, 1, 1, 0, 48'h0,    NO_FAULT, 5,  3'd3, 48'h52);
    vt[13] = mk(0, 1, 1, 0, 0, 48'h0,    NO_FAULT, 1,  3'd0, 48'h0);
    vt[14] = mk(1, 1, 1, 1, 0, 48'h0,    NO_FAULT, 4,  3'd1, 48'h18);

    m_valid = 1'b0; m_pop = 1'b0; m_req = 1'b0; m_push = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      for (int c = 0; c < vt[i].cycles; c++) begin
        rst_n       = vt[i].rst_n;
        clk_en      = vt[i].clk_en;
        imem_valid  = vt[i].valid;
        dec_ready   = vt[i].ready;
        redirect    = vt[i].redir;
        redirect_pc = vt[i].rpc;
        imem_data   = 48'h100 + m_fpc;
        imem_fault  = (m_fpc == vt[i].fault_pc);
        @(negedge clk);
        if (m_init) begin
          m_valid = !redirect && (sb.size() > 0);
          m_pop   = m_valid && dec_ready;
          m_req   = !m_halt && ((sb.size() < DEPTH) || m_pop);
          m_push  = m_req && imem_valid && !redirect;
          chk("imem_req", 64'(imem_req), 64'(m_req));
          chk("imem_addr", 64'(imem_addr), 64'(m_fpc));
          chk("dec_valid", 64'(dec_valid), 64'(m_valid));
          chk("count", 64'(count), 64'(sb.size()));
          if (m_valid) begin
            chk("dec_pc", 64'(dec_pc), 64'(sb[0].pc));
            chk("dec_instr", 64'(dec_instr), 64'(sb[0].instr));
            chk("dec_fault", 64'(dec_fault), 64'(sb[0].fault));
          end
          if (redirect) chk("redirect_kills_valid", 64'(dec_valid), 64'd0);
        end
        @(posedge clk);
        if (!rst_n) begin
          sb.delete();
          m_fpc  = RESET_PC;
          m_halt = 1'b0;
          m_init = 1'b1;
        end else if (m_init && clk_en) begin
          if (redirect) begin
            sb.delete();
            m_fpc  = redirect_pc;
            m_halt = 1'b0;
          end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) begin
              sb.push_back('{pc: m_fpc, instr: imem_data, fault: imem_fault});
              m_fpc = m_fpc + 48'(PC_INC);
              if (imem_fault) m_halt = 1'b1;
            end
          end
        end
        #1;
      end
      chk("phase_count", 64'(count), 64'(vt[i].exp_count));
      chk("phase_addr", 64'(imem_addr), 64'(vt[i].exp_addr));
      if (i == 3) chk("full_no_req", 64'(imem_req), 64'd0);
      if (i == 9) chk("halted_no_req", 64'(imem_req), 64'd0);
    end

    // Fetch-to-decode latency: one word after reset, observed across two cycles.
    rst_n = 1'b0; clk_en = 1'b1; imem_valid = 1'b0; dec_ready = 1'b0; redirect = 1'b0;
    imem_fault = 1'b0; imem_data = 48'h0; redirect_pc = 48'h0;
    @(posedge clk); #1;
    rst_n = 1'b1; imem_valid = 1'b1; dec_ready = 1'b1; imem_data = 48'h100;
    @(negedge clk);
`ifdef AMBER48_FETCH_QUEUE_BYPASS_EN
    chk("lat_same_cycle_valid", 64'(dec_valid), 64'd1);
    chk("lat_same_cycle_instr", 64'(dec_instr), 64'h100);
`else
    chk("lat_same_cycle_valid", 64'(dec_valid), 64'd0);
`endif
    @(posedge clk); #1;
    imem_valid = 1'b0;
    @(negedge clk);
`ifdef AMBER48_FETCH_QUEUE_BYPASS_EN
    chk("lat_next_valid", 64'(dec_valid), 64'd0);
    chk("lat_next_count", 64'(count), 64'd0);
`else
    chk("lat_next_valid", 64'(dec_valid), 64'd1);
    chk("lat_next_pc", 64'(dec_pc), 64'h0);
    chk("lat_next_instr", 64'(dec_instr), 64'h100);
`endif
    chk("lat_next_addr", 64'(imem_addr), 64'(PC_INC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/amber48_fetch_queue.md
Name: amber48_fetch_queue

Overview:
Parametrised instruction-fetch front end for the amber48 pipeline. It replaces the single IF pipeline register with a DEPTH-entry prefetch FIFO of {pc, instr, fault}. The block owns the fetch PC, drives the instruction memory, and presents fetched words to decode through a valid/ready handshake. Branch and trap redirects flush the queue and restart fetch at a new PC.

Parameters:
XLEN, 48, address and instruction width in bits.
DEPTH, 4, number of queue entries; power of two, at least 2.
PC_INC, BAU_BYTES (amber48_pkg), PC increment per fetched word.
RESET_PC, 0, fetch PC after reset.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
clk_en_i  in  1  global clock enable; all state holds when low
imem_req_o  out  1  fetch request for imem_addr_o
imem_addr_o  out  XLEN  current fetch PC
imem_data_i  in  XLEN  instruction word at imem_addr_o
imem_valid_i  in  1  imem_data_i valid this cycle (same-cycle response)
imem_fault_i  in  1  fetch fault; qualified by imem_valid_i
redirect_i  in  1  flush queue and restart fetch
redirect_pc_i  in  XLEN  new fetch PC
dec_valid_o  out  1  queue head valid
dec_ready_i  in  1  decode accepts head
dec_pc_o  out  XLEN  head PC
dec_instr_o  out  XLEN  head instruction
dec_fault_o  out  1  head carries fetch fault
count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_ni low at a clk_i edge, independent of clk_en_i): fetch_pc=RESET_PC, read/write pointers=0, count=0, halted=0. Outputs: dec_valid_o=0, count_o=0, imem_req_o=1 (and RESET_PC on imem_addr_o) once rst_ni is high. Payload outputs are don't-care while dec_valid_o=0. Reset asserted mid-operation discards all entries within one edge.
- imem_req_o = !halted && (count<DEPTH || pop), where pop = dec_valid_o && dec_ready_i. A full queue that is draining this cycle may accept a word.
- push = imem_req_o && imem_valid_i && !redirect_i. On push, write {fetch_pc, imem_data_i, imem_fault_i} at wptr, then fetch_pc += PC_INC (modulo 2^XLEN, wraps silently).
- If a pushed entry has fault=1, set halted=1: no further requests until a redirect. Entries already queued drain normally.
- Pop advances rptr. Simultaneous push and pop leaves count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately so full and empty are unambiguous.
- Redirect (priority over push and pop): the same edge sets count=0, rptr=wptr=0, fetch_pc=redirect_pc_i, halted=0. dec_valid_o is forced to 0 combinationally in the redirect cycle. The imem response in that cycle is discarded. A request to redirect_pc_i issues on the next cycle.
- imem_valid_i=0 means no push and fetch_pc holds; the request stays asserted.
- clk_en_i low: no state change, outputs stable.
- Latency without bypass: a word returned in cycle N is visible on dec_* in cycle N+1.
- dec_pc_o, dec_instr_o and dec_fault_o stay stable while dec_valid_o=1 and dec_ready_i=0.

Optional Feature:
AMBER48_FETCH_QUEUE_BYPASS_EN
- Defined: when count=0, push occurs and no redirect is active, imem data drives dec_* combinationally in the same cycle (dec_valid_o=1). If dec_ready_i=1, the word is consumed without being written to the queue. Zero-cycle fetch-to-decode latency.
- Undefined: no combinational path from imem_* to dec_*. Minimum latency is one cycle, and the path is registered only.

Test Plan:
- Reset then imem_valid_i=1 continuously, dec_ready_i=1, data=0x100+pc -> dec_pc_o sequence 0, PC_INC, 2*PC_INC…, one word per cycle, count_o never above 1 (0 with bypass).
- dec_ready_i=0 with imem_valid_i=1 -> count_o reaches 4 after 4 cycles, imem_req_o=0, fetch_pc=4*PC_INC. Raise dec_ready_i -> words come out in order PCs 0..3*PC_INC, no loss or duplication.
- Full queue, dec_ready_i=1 and imem_valid_i=1 in the same cycle -> one push plus one pop, count_o stays 4, order preserved across pointer wrap (at least 3 laps).
- Queue holding 3 entries, redirect_i=1 with redirect_pc_i=0x1000 -> dec_valid_o=0 that cycle, count_o=0 next cycle, next imem_addr_o=0x1000, and the next dec_pc_o is 0x1000.
- imem_fault_i=1 on the word at PC 2*PC_INC -> entry reaches decode with dec_fault_o=1, imem_req_o stays 0 afterwards, and redirect to 0x40 resumes fetch.
- clk_en_i=0 for 5 cycles mid-stream, and rst_ni=0 while count_o=3 -> first holds all outputs unchanged; reset gives count_o=0, dec_valid_o=0, imem_addr_o=RESET_PC after one edge.
